mlp_layer_engine: RTL and testbench
===================================

MLP_LAYER_ENGINE -- requirements
Module: mlp_layer_engine

Interface
REQ-001 Parameter WIDTH, default 18: signed fixed-point operand width, taken from tdata[WIDTH-1:0].
REQ-002 Parameter FRAC, default 14: fraction bits of operands and results.
REQ-003 Parameter IN_LEN, default 784: input vector length, also weights per neuron.
REQ-004 Parameter NEURONS, default 30: neurons per layer pass.
REQ-005 Parameter ACC_WIDTH, default 48: signed accumulator width.
REQ-006 s00_axis_aclk  in  1  single clock for all logic.
REQ-007 s00_axis_aresetn  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  level; a high level sampled in IDLE begins a layer pass.
REQ-009 relu_en  in  1  sampled with start; 1 clamps negative results to 0.
REQ-010 ready  out  1  high only in IDLE.
REQ-011 cl_num  out  clog2(NEURONS)  index of largest neuron result of the last pass.
REQ-012 s00_axis_tdata/tvalid/tready/tstrb/tlast  in/in/out/in/in  32/1/1/4/1  input stream; tstrb and tlast ignored.
REQ-013 m00_axis_tdata/tvalid/tready/tlast  out/out/in/out  32/1/1/1  per-neuron result stream.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD_IN, MAC, BIAS, OUT.
REQ-015 IDLE->LOAD_IN on start=1; accumulator, word index and neuron index cleared on this transition.
REQ-016 LOAD_IN: each accepted beat (tvalid&tready) stored to input buffer[idx]; after beat IN_LEN-1 -> MAC.
REQ-017 MAC: each accepted beat adds signed weight*buffer[idx] (2*WIDTH product, sign-extended) to accumulator; after beat IN_LEN-1 -> BIAS.
REQ-018 BIAS: one accepted beat adds bias<<<FRAC to accumulator; result computed and registered next edge; -> OUT.
REQ-019 Result = accumulator>>>FRAC, saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1], then ReLU if relu_en latched.
REQ-020 s00_axis_tready high exactly in LOAD_IN, MAC, BIAS; zero in IDLE and OUT.
REQ-021 OUT: m00_axis_tvalid high, tdata = result sign-extended to 32 bits, held stable until m00_axis_tready.
REQ-022 m00_axis_tlast high with the beat of neuron NEURONS-1.
REQ-023 On output handshake: accumulator cleared; if last neuron -> IDLE, else -> MAC with neuron index +1.
REQ-024 Input buffer SHALL be reused unchanged for all NEURONS of a pass.
REQ-025 start high outside IDLE ignored; start held high after completion starts a new pass immediately.
REQ-026 Output backpressure stalls the pass indefinitely without data loss.
REQ-027 One MAC per accepted beat; no beat dropped or double-counted under arbitrary tvalid gaps.

Reset
REQ-028 Reset SHALL force IDLE, ready=1, s00_axis_tready=0, m00_axis_tvalid=0, m00_axis_tdata=0, m00_axis_tlast=0, cl_num=0, accumulator and indices 0.
REQ-029 Reset mid-pass aborts it; input buffer contents are don't-care after reset.

Configuration
REQ-030 Macro MLP_ARGMAX_EN defined: argmax tracker compares each result at the output handshake; strictly greater replaces, ties keep lower index; cl_num updated when the pass ends and held until the next pass ends.
REQ-031 MLP_ARGMAX_EN undefined: no tracker logic; cl_num tied to 0.

Verification (WIDTH=18, FRAC=0, IN_LEN=4, NEURONS=3, MLP_ARGMAX_EN defined)
REQ-032 Reset released, no start -> ready=1, both tvalid/tready 0, cl_num=0.
REQ-033 Input {1,2,3,4}; weights n0 {1,1,1,1} b=0, n1 {0,0,0,1} b=10, n2 {-1,0,0,0} b=0; relu_en=0 -> outputs 10,14,-1, tlast on third, cl_num=1, ready returns 1.
REQ-034 Same with relu_en=1 -> third output 0; weights all 0x1FFFF, input all 0x1FFFF -> output saturates to 131071.
REQ-035 m00_axis_tready held 0 for 20 cycles at first result -> tdata stable, s00_axis_tready 0 throughout, then correct continuation.
REQ-036 Results {5,5,3} -> cl_num=0 (tie keeps lower index); reset asserted during MAC of neuron 1 -> all REQ-028 values next cycle, new pass then correct.

Source files
------------

// File: rtl/mlp_layer_engine_if.sv
// Stream interface for mlp_layer_engine.
// Contains the AXI4-Stream input (s00) and the per-neuron result stream (m00).
// The engine takes the slave modport. The stimulus side takes the master modport.
interface mlp_layer_engine_if;
    logic [31:0] s00_axis_tdata;
    logic        s00_axis_tvalid;
    logic        s00_axis_tready;
    logic [3:0]  s00_axis_tstrb;
    logic        s00_axis_tlast;

    logic [31:0] m00_axis_tdata;
    logic        m00_axis_tvalid;
    logic        m00_axis_tready;
    logic        m00_axis_tlast;

    modport slave (
        input  s00_axis_tdata, s00_axis_tvalid, s00_axis_tstrb, s00_axis_tlast,
        output s00_axis_tready,
        output m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast,
        input  m00_axis_tready
    );

    modport master (
        output s00_axis_tdata, s00_axis_tvalid, s00_axis_tstrb, s00_axis_tlast,
        input  s00_axis_tready,
        input  m00_axis_tdata, m00_axis_tvalid, m00_axis_tlast,
        output m00_axis_tready
    );
endinterface

// File: rtl/mlp_layer_engine.sv
// mlp_layer_engine: one fully-connected layer pass computed over a single stream.
// The stream delivers IN_LEN input words. For each of the NEURONS neurons it then
// delivers IN_LEN weights and one bias. Each neuron produces one saturated result,
// with optional ReLU, on the m00 stream.
// Optional feature: define MLP_ARGMAX_EN to enable the argmax tracker that drives
// cl_num. When the macro is undefined, cl_num is tied to 0.
module mlp_layer_engine #(
    parameter int WIDTH     = 18,
    parameter int FRAC      = 14,
    parameter int IN_LEN    = 784,
    parameter int NEURONS   = 30,
    parameter int ACC_WIDTH = 48
) (
    input  logic s00_axis_aclk,
    input  logic s00_axis_aresetn,
    input  logic start,
    input  logic relu_en,
    output logic ready,
    output logic [((NEURONS > 1) ? $clog2(NEURONS) : 1)-1:0] cl_num,
    mlp_layer_engine_if.slave axis
);
    localparam int IDX_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int NRN_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IN_LEN - 1);
    localparam logic [NRN_W-1:0] NRN_LAST = NRN_W'(NEURONS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD_IN, MAC, BIAS, OUT} state_e;

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NRN_W-1:0]             neuron_q, neuron_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         relu_q, relu_d;
    logic signed [WIDTH-1:0]      result_q, result_d;
    logic signed [WIDTH-1:0]      buffer_mem [IN_LEN];

    logic                         in_beat, out_beat;
    logic signed [WIDTH-1:0]      in_word;
    logic signed [2*WIDTH-1:0]    product;
    logic signed [ACC_WIDTH-1:0]  product_ext, bias_ext, acc_biased, acc_shifted;
    logic signed [WIDTH-1:0]      result_sat;
    logic                         unused_in;

    assign in_word  = axis.s00_axis_tdata[WIDTH-1:0];
    assign in_beat  = axis.s00_axis_tvalid && axis.s00_axis_tready;
    assign out_beat = axis.m00_axis_tvalid && axis.m00_axis_tready;
    assign unused_in = ^{axis.s00_axis_tdata, axis.s00_axis_tstrb, axis.s00_axis_tlast};

    assign ready                = (state_q == IDLE);
    assign axis.s00_axis_tready = (state_q == LOAD_IN) || (state_q == MAC) || (state_q == BIAS);
    assign axis.m00_axis_tvalid = (state_q == OUT);
    assign axis.m00_axis_tlast  = (state_q == OUT) && (neuron_q == NRN_LAST);
    assign axis.m00_axis_tdata  = {{(32-WIDTH){result_q[WIDTH-1]}}, result_q};

    // Datapath: MAC product, bias alignment, rescale, saturate, optional ReLU
    always_comb begin
        product     = (2*WIDTH)'(in_word) * (2*WIDTH)'(buffer_mem[idx_q]);
        product_ext = {{(ACC_WIDTH-2*WIDTH){product[2*WIDTH-1]}}, product};
        bias_ext    = {{(ACC_WIDTH-WIDTH){in_word[WIDTH-1]}}, in_word} <<< FRAC;
        acc_biased  = acc_q + bias_ext;
        acc_shifted = acc_biased >>> FRAC;
        if (acc_shifted > SAT_MAX) begin
            result_sat = SAT_MAX[WIDTH-1:0];
        end else if (acc_shifted < SAT_MIN) begin
            result_sat = SAT_MIN[WIDTH-1:0];
        end else begin
            result_sat = acc_shifted[WIDTH-1:0];
        end
        if (relu_q && result_sat[WIDTH-1]) begin
            result_sat = '0;
        end
    end

    // Next-state and control: stream phases, index counters, accumulator
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        idx_d    = idx_q;
        neuron_d = neuron_q;
        acc_d    = acc_q;
        relu_d   = relu_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD_IN;
                    acc_d    = '0;
                    idx_d    = '0;
                    neuron_d = '0;
                    relu_d   = relu_en;
                end
            end
            LOAD_IN: begin
                if (in_beat) begin
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) state_d = MAC;
                end
            end
            MAC: begin
                if (in_beat) begin
                    acc_d = acc_q + product_ext;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) state_d = BIAS;
                end
            end
            BIAS: begin
                if (in_beat) begin
                    acc_d    = acc_biased;
                    result_d = result_sat;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (out_beat) begin
                    acc_d = '0;
                    if (neuron_q == NRN_LAST) begin
                        state_d  = IDLE;
                        neuron_d = '0;
                    end else begin
                        state_d  = MAC;
                        neuron_d = neuron_q + NRN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and result registers, cleared by async reset
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!s00_axis_aresetn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            neuron_q <= '0;
            acc_q    <= '0;
            relu_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            neuron_q <= neuron_d;
            acc_q    <= acc_d;
            relu_q   <= relu_d;
            result_q <= result_d;
        end
    end

    // Input vector buffer, written during LOAD_IN and reused by every neuron
    always_ff @(posedge s00_axis_aclk) begin
        // NOTE: the buffer is not reset. Every entry is rewritten before it is read in a pass.
        if (state_q == LOAD_IN && in_beat) begin
            buffer_mem[idx_q] <= in_word;
        end
    end

`ifdef MLP_ARGMAX_EN
    logic signed [WIDTH-1:0] best_val_q, best_val_d;
    logic [NRN_W-1:0]        best_idx_q, best_idx_d;
    logic [NRN_W-1:0]        cl_num_q, cl_num_d;
    logic                    take_new;

    // Argmax tracker: a strictly greater result replaces the best, so ties keep the lower index
    always_comb begin
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        cl_num_d   = cl_num_q;
        take_new   = (neuron_q == '0) || (result_q > best_val_q);
        if (out_beat) begin
            if (take_new) begin
                best_val_d = result_q;
                best_idx_d = neuron_q;
            end
            if (neuron_q == NRN_LAST) begin
                cl_num_d = take_new ? neuron_q : best_idx_q;
            end
        end
    end

    // Argmax registers. cl_num holds its value until the next pass completes.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            best_val_q <= '0;
            best_idx_q <= '0;
            cl_num_q   <= '0;
        end else begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            cl_num_q   <= cl_num_d;
        end
    end

    assign cl_num = cl_num_q;
`else
    assign cl_num = '0;
`endif

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Self-checking bench for mlp_layer_engine (WIDTH=18, FRAC=0, IN_LEN=4, NEURONS=3).
// Expected neuron results are pushed to a scoreboard when each bias beat is driven.
// A monitor pops and compares them on every output handshake.
module tb_mlp_layer_engine;
    localparam int WIDTH     = 18;
    localparam int FRAC      = 0;
    localparam int IN_LEN    = 4;
    localparam int NEURONS   = 3;
    localparam int ACC_WIDTH = 48;
    localparam int CL_W      = 2;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            relu_en;
    logic            ready;
    logic [CL_W-1:0] cl_num;

    mlp_layer_engine_if axis ();

    mlp_layer_engine #(
        .WIDTH(WIDTH), .FRAC(FRAC), .IN_LEN(IN_LEN),
        .NEURONS(NEURONS), .ACC_WIDTH(ACC_WIDTH)
    ) u_dut (
        .s00_axis_aclk    (clk),
        .s00_axis_aresetn (rst_n),
        .start            (start),
        .relu_en          (relu_en),
        .ready            (ready),
        .cl_num           (cl_num),
        .axis             (axis)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   in_v [IN_LEN];
    int   w    [NEURONS][IN_LEN];
    int   b    [NEURONS];
    bit   stall_req  = 0;
    bit   stall_done = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_neuron(input int n, input bit relu);
        longint acc = 0;
        longint sh;
        for (int i = 0; i < IN_LEN; i++) acc += longint'(in_v[i]) * longint'(w[n][i]);
        acc += longint'(b[n]) <<< FRAC;
        sh = acc >>> FRAC;
        if (sh > (longint'(1) <<< (WIDTH-1)) - 1) sh = (longint'(1) <<< (WIDTH-1)) - 1;
        if (sh < -(longint'(1) <<< (WIDTH-1)))    sh = -(longint'(1) <<< (WIDTH-1));
        if (relu && sh < 0) sh = 0;
        return int'(sh);
    endfunction

    // Drive one input beat with a random idle gap; called and returns on a negedge
    task automatic send_beat(input int v);
        bit accepted = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        axis.s00_axis_tdata  = 32'(v);
        axis.s00_axis_tvalid = 1'b1;
        for (int c = 0; c < 500 && !accepted; c++) begin
            if (axis.s00_axis_tready) accepted = 1;
            @(negedge clk);
        end
        axis.s00_axis_tvalid = 1'b0;
        if (!accepted) check("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 500 && !ready; c++) @(negedge clk);
        check("ready_after_pass", ready, 1);
    endtask

    task automatic start_pass(input bit relu);
        start   = 1'b1;
        relu_en = relu;
        @(negedge clk);
        start   = 1'b0;
        check("busy_after_start", ready, 0);
        for (int i = 0; i < IN_LEN; i++) send_beat(in_v[i]);
    endtask

    task automatic send_neuron(input int n, input bit relu);
        exp_t e;
        for (int i = 0; i < IN_LEN; i++) send_beat(w[n][i]);
        e.data = 32'(model_neuron(n, relu));
        e.last = (n == NEURONS-1);
        sb_q.push_back(e);
        send_beat(b[n]);
    endtask

    task automatic run_pass(input bit relu);
        int best   = 0;
        int best_v = 0;
        int r;
        start_pass(relu);
        for (int n = 0; n < NEURONS; n++) begin
            r = model_neuron(n, relu);
            if (n == 0 || r > best_v) begin
                best_v = r;
                best   = n;
            end
            send_neuron(n, relu);
        end
        wait_idle();
`ifdef MLP_ARGMAX_EN
        check("cl_num", 32'(cl_num), 32'(best));
`else
        check("cl_num", 32'(cl_num), 32'd0);
`endif
        check("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic load_pattern_a();
        in_v = '{1, 2, 3, 4};
        w    = '{'{1, 1, 1, 1}, '{0, 0, 0, 1}, '{-1, 0, 0, 0}};
        b    = '{0, 10, 0};
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"},  ready, 1);
        check({tag, "_s_rdy"},  axis.s00_axis_tready, 0);
        check({tag, "_m_vld"},  axis.m00_axis_tvalid, 0);
        check({tag, "_m_data"}, axis.m00_axis_tdata, 0);
        check({tag, "_m_last"}, axis.m00_axis_tlast, 0);
        check({tag, "_cl_num"}, 32'(cl_num), 0);
    endtask

    // Output monitor: sample mid-cycle and compare each handshake against the scoreboard
    always @(negedge clk) begin
        #1;
        if (axis.m00_axis_tvalid && axis.m00_axis_tready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_data", axis.m00_axis_tdata, mon_e.data);
                check("out_last", axis.m00_axis_tlast, mon_e.last);
            end
        end
    end

    // Backpressure: hold m00 tready low for 20 cycles once the first result appears
    initial begin
        axis.m00_axis_tready = 1'b1;
        forever begin
            @(posedge stall_req);
            axis.m00_axis_tready = 1'b0;
            for (int c = 0; c < 500 && !axis.m00_axis_tvalid; c++) @(negedge clk);
            if (axis.m00_axis_tvalid) begin
                logic [31:0] snap;
                snap = axis.m00_axis_tdata;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    check("stall_data",  axis.m00_axis_tdata, snap);
                    check("stall_valid", axis.m00_axis_tvalid, 1);
                    check("stall_s_rdy", axis.s00_axis_tready, 0);
                end
                stall_done = 1'b1;
            end else begin
                check("stall_wait_timeout", 32'd0, 32'd1);
            end
            axis.m00_axis_tready = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                = 1'b0;
        start                = 1'b0;
        relu_en              = 1'b0;
        axis.s00_axis_tvalid = 1'b0;
        axis.s00_axis_tdata  = '0;
        axis.s00_axis_tstrb  = 4'hF;
        axis.s00_axis_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_state("rst");

        // Reference pattern, then the same pattern with ReLU enabled
        load_pattern_a();
        run_pass(1'b0);
        run_pass(1'b1);

        // Saturation: all operands at the maximum positive value
        for (int i = 0; i < IN_LEN; i++) in_v[i] = 'h1FFFF;
        for (int n = 0; n < NEURONS; n++) begin
            for (int i = 0; i < IN_LEN; i++) w[n][i] = 'h1FFFF;
            b[n] = 0;
        end
        run_pass(1'b0);

        // Tie between neurons 0 and 1 must keep the lower index
        in_v = '{1, 0, 0, 0};
        w    = '{'{5, 0, 0, 0}, '{5, 0, 0, 0}, '{3, 0, 0, 0}};
        b    = '{0, 0, 0};
        run_pass(1'b0);

        // Output backpressure on the first result
        load_pattern_a();
        stall_req = 1'b1;
        run_pass(1'b0);
        check("stall_done", stall_done, 1);
        stall_req = 1'b0;

        // Reset during MAC of neuron 1, then a clean pass
        start_pass(1'b0);
        send_neuron(0, 1'b0);
        send_beat(w[1][0]);
        send_beat(w[1][1]);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        sb_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        run_pass(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
